function_code_sender: RTL and testbench
=======================================

// Module: function_code_sender
// PURPOSE
//  Sender side of the inter-interface function-code link. Syncs and debounces one user
//  interface's confirm button, latches the 3-bit function selection and drives it as
//  (A,B,C) to the opposite interface's display validator, with a valid flag and a hold time.
//  Sits between one user's switch/button inputs and the other interface's 7-seg decode path.
// PARAMETERS
//  DEBOUNCE_CYCLES  16'd50000  consecutive cycles confirm must be stable high (>=1)
//  HOLD_CYCLES      24'd0      cycles code_valid stays high after capture; 0 = hold until clear
// PORTS
//  clk          input   1  system clock, rising edge
//  reset        input   1  asynchronous, active-high reset
//  sw           input   3  user function selection {A,B,C}, asynchronous
//  confirm_btn  input   1  user confirm button, raw, active-high, asynchronous
//  clear        input   1  synchronous, 1-cycle pulse: withdraw current code
//  code_out     output  3  latched function code {A,B,C} to opposite interface
//  code_valid   output  1  1 = code_out is a live selection
//  reject       output  1  1-cycle pulse: selection refused (CODE_FILTER_EN only)
//  busy         output  1  1 while FSM is not IDLE
// BEHAVIOUR
//  Reset (async): code_out=3'b000, code_valid=0, reject=0, busy=0, FSM=IDLE,
//   sync flops=0, debounce and hold counters=0. Reset mid-operation aborts at once.
//  Inputs: sw and confirm_btn each pass through a 2-flop synchronizer before use.
//  Debounce: counter increments while synced confirm=1 and saturates at DEBOUNCE_CYCLES;
//   clears to 0 on any synced 0. press = 1-cycle pulse when counter first reaches
//   DEBOUNCE_CYCLES. A held button yields exactly one press; re-arms only after release.
//  FSM states: IDLE, CAPTURE, ACTIVE.
//   IDLE   : press -> CAPTURE.
//   CAPTURE: one cycle; code_out <= synced sw; hold counter <= HOLD_CYCLES; -> ACTIVE.
//   ACTIVE : code_valid=1. clear -> IDLE. HOLD_CYCLES!=0 and hold counter reaches 1
//            -> IDLE. press -> CAPTURE (recapture; code_valid stays 1 through CAPTURE).
//  Latency: confirm_btn high from edge N, stable -> press at edge N+2+DEBOUNCE_CYCLES;
//   code_out updates and code_valid=1 from edge N+3+DEBOUNCE_CYCLES.
//  Hold: code_valid high exactly HOLD_CYCLES cycles, counted from the first ACTIVE cycle.
//  code_valid: registered; 1 in ACTIVE, and in CAPTURE only when entered from ACTIVE.
//  code_out: keeps last latched value in IDLE (consumers qualify with code_valid).
//  busy: 1 in CAPTURE and ACTIVE.
//  Simultaneous: clear and press in the same ACTIVE cycle -> clear wins, IDLE, press is
//   dropped. clear in IDLE or CAPTURE is ignored. Hold expiry and press in the same
//   cycle -> press wins (recapture).
//  Counter widths: debounce 16 bits, hold 24 bits; no wrap-around (both saturate).
// CONFIGURATION
//  CODE_FILTER_EN defined: in CAPTURE, synced sw==3'b000 or 3'b111 (no function) is refused.
//   code_out is not updated, reject pulses for 1 cycle, and FSM -> previous state:
//   IDLE, or ACTIVE with the old code and its hold counter unchanged.
//  CODE_FILTER_EN undefined: all 8 codes are accepted; reject is tied to 0.
// TESTING (bench: DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
//  1. Reset asserted mid-ACTIVE -> code_out=000, code_valid=0, busy=0 with no clock edge.
//  2. sw=010, confirm high from edge N, held 20 cycles -> code_out=010 and code_valid=1
//     from edge N+7; valid for exactly 8 cycles; one capture only.
//  3. confirm bouncing 1,0,1,1,0 then stable high -> no capture until 4 stable synced
//     cycles; then a single capture.
//  4. ACTIVE with 010, sw=101, new debounced press -> code_out=101, code_valid never
//     drops, hold restarts at 8; clear and press in same cycle -> IDLE, code_valid=0.
//  5. HOLD_CYCLES=0: capture 011 -> code_valid stays 1 for 1000 cycles until clear pulse.
//  6. CODE_FILTER_EN: ACTIVE with 010, sw=111 press -> reject 1 cycle, code_out stays 010,
//     code_valid 1; without macro -> code_out=111, reject stays 0.

Source files
------------

// File: rtl/function_code_sender.sv
// ---------------------------------------------------------------------------
// function_code_sender
//
// Sender side of the inter-interface function-code link. The user's raw
// confirm button is synchronised and debounced into a single press pulse; a
// press latches the synchronised 3-bit function selection {A,B,C} and
// presents it to the opposite interface with a valid flag and an optional
// hold time.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synced-high cycles needed for a press (>= 1)
//   HOLD_CYCLES      cycles code_valid stays high after capture; 0 = until clear
//
// Optional feature macro: CODE_FILTER_EN
//   defined   : selections 3'b000 and 3'b111 are refused at capture time
//               (code_out untouched, reject pulses, FSM returns to where it was)
//   undefined : all 8 codes accepted, reject tied low
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   sw[2:0]      in   function selection {A,B,C}, asynchronous
//   confirm_btn  in   raw confirm button, active-high, asynchronous
//   clear        in   synchronous 1-cycle pulse, withdraws the current code
//   code_out     out  latched function code {A,B,C}
//   code_valid   out  code_out is a live selection
//   reject       out  1-cycle pulse, selection refused
//   busy         out  FSM is not IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no live code; waiting for a debounced press
// CAPTURE | one cycle: latch synced sw, load hold timer (or refuse)
// ACTIVE  | code_out is live; clear, hold expiry or a new press leave
// ---------------------------------------------------------------------------
module function_code_sender #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] HOLD_CYCLES     = 24'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       confirm_btn,
  input  logic       clear,
  output logic [2:0] code_out,
  output logic       code_valid,
  output logic       reject,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [2:0]  sw_meta;
  logic [2:0]  sw_sync;
  logic        btn_meta;
  logic        btn_sync;

  logic [15:0] db_cnt;
  logic        press;

  logic [23:0] hold_cnt;
  logic [23:0] hold_n;
  logic [2:0]  code_n;
  logic        valid_n;
  logic        refuse;

  // two-flop synchronisers for the asynchronous user inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta  <= 3'b000;
      sw_sync  <= 3'b000;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= confirm_btn;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: count consecutive synced-high cycles, saturating at the
  // threshold. press fires on the cycle the count lands on the threshold, so
  // a held button gives one press and re-arms only after a synced low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= 16'd0;
      press  <= 1'b0;
    end else if (!btn_sync) begin
      db_cnt <= 16'd0;
      press  <= 1'b0;
    end else begin
      if (db_cnt != DEBOUNCE_CYCLES) begin
        db_cnt <= db_cnt + 16'd1;
      end
      press <= (db_cnt == DEBOUNCE_CYCLES - 16'd1);
    end
  end

`ifdef CODE_FILTER_EN
  logic reject_q;

  // "no function" selections are refused
  assign refuse = (sw_sync == 3'b000) || (sw_sync == 3'b111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject_q <= 1'b0;
    end else begin
      reject_q <= (state == CAPTURE) && refuse;
    end
  end

  assign reject = reject_q;
`else
  assign refuse = 1'b0;
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      code_out   <= 3'b000;
      code_valid <= 1'b0;
      hold_cnt   <= 24'd0;
    end else begin
      state      <= state_n;
      code_out   <= code_n;
      code_valid <= valid_n;
      hold_cnt   <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code_out;
    hold_n  = hold_cnt;
    valid_n = code_valid;

    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (press) begin
          state_n = CAPTURE;
        end
      end

      CAPTURE: begin
        if (refuse) begin
          // code_valid is high in CAPTURE only when we came from ACTIVE, so
          // it tells us where to return; the old code and timer are kept.
          if (code_valid) begin
            state_n = ACTIVE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          code_n  = sw_sync;
          hold_n  = HOLD_CYCLES;
          valid_n = 1'b1;
          state_n = ACTIVE;
        end
      end

      ACTIVE: begin
        if (clear) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (press) begin
          // recapture; the hold timer is frozen until CAPTURE reloads it
          state_n = CAPTURE;
          valid_n = 1'b1;
        end else if ((HOLD_CYCLES != 24'd0) && (hold_cnt == 24'd1)) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else begin
          valid_n = 1'b1;
          if (hold_cnt != 24'd0) begin
            hold_n = hold_cnt - 24'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_function_code_sender.sv
module tb_function_code_sender;

  localparam int D    = 4;
  localparam int MAXE = 16384;

  logic       clk;
  logic       reset;
  logic [2:0] sw;
  logic       confirm_btn;
  logic       clear;

  logic [2:0] code_a, code_b;
  logic       valid_a, valid_b;
  logic       rej_a, rej_b;
  logic       busy_a, busy_b;

  int n_cmp;
  int n_bad;

  // dut_a: hold 8 cycles; dut_b: hold until clear
  function_code_sender #(.DEBOUNCE_CYCLES(16'd4), .HOLD_CYCLES(24'd8)) dut_a (
    .clk(clk), .reset(reset), .sw(sw), .confirm_btn(confirm_btn), .clear(clear),
    .code_out(code_a), .code_valid(valid_a), .reject(rej_a), .busy(busy_a)
  );

  function_code_sender #(.DEBOUNCE_CYCLES(16'd4), .HOLD_CYCLES(24'd0)) dut_b (
    .clk(clk), .reset(reset), .sw(sw), .confirm_btn(confirm_btn), .clear(clear),
    .code_out(code_b), .code_valid(valid_b), .reject(rej_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input history per clock edge since reset; press and hold expiry are
  // derived from run lengths and edge distances rather than counters.
  bit       conf_h [MAXE];
  bit [2:0] sw_h   [MAXE];
  bit       clr_h  [MAXE];
  int       e;

  int       ms     [2];   // 0 idle, 1 capture, 2 active
  bit       mfa    [2];   // capture was entered from active
  bit [2:0] mcode  [2];
  bit       mvalid [2];
  bit       mrej   [2];
  bit       mbusy  [2];
  int       mcap   [2];   // edge at which the live code's hold began

  function automatic int hold_of(input int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic bit conf_at(input int i);
    if (i < 0 || i >= MAXE) return 1'b0;
    return conf_h[i];
  endfunction

  // press visible after edge p: the D raw samples taken two edges earlier
  // are all high and the sample before them is low
  function automatic bit press_after(input int p);
    if (conf_at(p - 2 - D)) return 1'b0;
    for (int k = 0; k < D; k++) begin
      if (!conf_at(p - 2 - k)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit refused(input bit [2:0] s);
`ifdef CODE_FILTER_EN
    return (s == 3'b000) || (s == 3'b111);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e = 0;
      for (int i = 0; i < 2; i++) begin
        ms[i] = 0; mfa[i] = 1'b0; mcode[i] = 3'b000; mvalid[i] = 1'b0;
        mrej[i] = 1'b0; mbusy[i] = 1'b0; mcap[i] = 0;
      end
    end else begin
      if (e < MAXE) begin
        conf_h[e] = confirm_btn;
        sw_h[e]   = sw;
        clr_h[e]  = clear;
      end
      for (int i = 0; i < 2; i++) begin
        mrej[i] = 1'b0;
        case (ms[i])
          0: if (press_after(e - 1)) begin ms[i] = 1; mfa[i] = 1'b0; end
          1: begin
            if (refused(sw_h[e - 2])) begin
              mrej[i] = 1'b1;
              if (mfa[i]) begin ms[i] = 2; mcap[i] += 2; end
              else ms[i] = 0;
            end else begin
              mcode[i] = sw_h[e - 2];
              mcap[i]  = e;
              ms[i]    = 2;
            end
          end
          default: begin
            if (clr_h[e]) ms[i] = 0;
            else if (press_after(e - 1)) begin ms[i] = 1; mfa[i] = 1'b1; end
            else if (hold_of(i) != 0 && e - mcap[i] == hold_of(i)) ms[i] = 0;
          end
        endcase
        mvalid[i] = (ms[i] == 2) || (ms[i] == 1 && mfa[i]);
        mbusy[i]  = (ms[i] != 0);
      end
      e++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("a.code_out",   int'(code_a),  int'(mcode[0]));
      chk("a.code_valid", int'(valid_a), int'(mvalid[0]));
      chk("a.reject",     int'(rej_a),   int'(mrej[0]));
      chk("a.busy",       int'(busy_a),  int'(mbusy[0]));
      chk("b.code_out",   int'(code_b),  int'(mcode[1]));
      chk("b.code_valid", int'(valid_b), int'(mvalid[1]));
      chk("b.reject",     int'(rej_b),   int'(mrej[1]));
      chk("b.busy",       int'(busy_b),  int'(mbusy[1]));
    end
  end

  // ends 1 time unit after the n-th rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cur;
    int run;

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    sw = 3'b000;
    confirm_btn = 1'b0;
    clear = 1'b0;
    #3;
    chk("rst_code",  int'(code_a),  0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_busy",  int'(busy_a),  0);
    chk("rst_rej",   int'(rej_a),   0);
    step(2);
    reset = 1'b0;
    step(2);

    // held press: code from edge N+7, valid exactly 8 cycles, single capture
    sw = 3'b010; confirm_btn = 1'b1;          // first sampled at N
    step(7);  chk("t2_valid_n6", int'(valid_a), 0);
    step(1);  chk("t2_code_n7",  int'(code_a),  2);
              chk("t2_valid_n7", int'(valid_a), 1);
    step(7);  chk("t2_valid_n14", int'(valid_a), 1);
    step(1);  chk("t2_valid_n15", int'(valid_a), 0);
    step(4);  confirm_btn = 1'b0;
    step(2);  chk("t2_once_valid", int'(valid_a), 0);
              chk("t2_once_busy",  int'(busy_a),  0);
    step(3);

    // bounce 1,0,1,1,0 then stable high
    sw = 3'b100;
    confirm_btn = 1'b1; step(1);
    confirm_btn = 1'b0; step(1);
    confirm_btn = 1'b1; step(1);
    confirm_btn = 1'b1; step(1);
    confirm_btn = 1'b0; step(1);
    confirm_btn = 1'b1;                       // stable run starts at N
    step(6);  chk("t3_busy_n5",  int'(busy_a),  0);
    step(1);  chk("t3_busy_n6",  int'(busy_a),  1);
              chk("t3_valid_n6", int'(valid_a), 0);
    step(1);  chk("t3_code_n7",  int'(code_a),  4);
              chk("t3_valid_n7", int'(valid_a), 1);
    confirm_btn = 1'b0;
    step(2);

    // async reset while ACTIVE, no clock edge needed
    #2;
    reset = 1'b1;
    #1;
    chk("t1_code",  int'(code_a),  0);
    chk("t1_valid", int'(valid_a), 0);
    chk("t1_busy",  int'(busy_a),  0);
    chk("t1b_valid", int'(valid_b), 0);
    step(2);
    reset = 1'b0;
    step(2);

    // recapture with press winning over hold expiry, then clear beats press
    sw = 3'b010; confirm_btn = 1'b1;          // k
    step(8);  chk("t4_code1", int'(code_a), 2);
    confirm_btn = 1'b0;
    step(1);  sw = 3'b101; confirm_btn = 1'b1; // k+9
    step(6);  chk("t4_valid_k15", int'(valid_a), 1);
    step(1);  chk("t4_valid_k16", int'(valid_a), 1);
              chk("t4_busy_k16",  int'(busy_a),  1);
    step(1);  chk("t4_code2",     int'(code_a),  5);
              chk("t4_valid_k17", int'(valid_a), 1);
    confirm_btn = 1'b0;
    step(1);  sw = 3'b110; confirm_btn = 1'b1; // k+18
    step(6);  chk("t4_valid_k24", int'(valid_a), 1);
    clear = 1'b1;
    step(1);  clear = 1'b0;
              chk("t4_clr_valid", int'(valid_a), 0);
              chk("t4_clr_busy",  int'(busy_a),  0);
              chk("t4_clr_code",  int'(code_a),  5);
    step(1);  chk("t4_drop_busy", int'(busy_a),  0);
    confirm_btn = 1'b0;
    step(10);

    // unlimited hold on dut_b
    sw = 3'b011; confirm_btn = 1'b1;
    step(8);  chk("t5_code", int'(code_b), 3);
    confirm_btn = 1'b0;
    step(1000);
    chk("t5_valid_b", int'(valid_b), 1);
    chk("t5_valid_a", int'(valid_a), 0);
    clear = 1'b1;
    step(1);  clear = 1'b0;
    chk("t5_cleared", int'(valid_b), 0);
    step(3);

    // "no function" selection during ACTIVE
    sw = 3'b010; confirm_btn = 1'b1;          // m
    step(8);  chk("t6_code1", int'(code_a), 2);
    confirm_btn = 1'b0;
    step(1);  sw = 3'b111; confirm_btn = 1'b1;
    step(8);
`ifdef CODE_FILTER_EN
    chk("t6_reject", int'(rej_a),   1);
    chk("t6_code",   int'(code_a),  2);
    chk("t6_valid",  int'(valid_a), 1);
    confirm_btn = 1'b0;
    step(1);
    chk("t6_reject_end", int'(rej_a),   0);
    chk("t6_hold_kept",  int'(valid_a), 0);
`else
    chk("t6_reject", int'(rej_a),   0);
    chk("t6_code",   int'(code_a),  7);
    chk("t6_valid",  int'(valid_a), 1);
    confirm_btn = 1'b0;
    step(1);
    chk("t6_reject_end", int'(rej_a), 0);
`endif
    step(5);

    // randomized traffic checked by the model every cycle
    cur = 0;
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        cur = (cur == 0) ? 1 : 0;
        run = (cur == 1) ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 4));
      end
      confirm_btn = (cur == 1);
      run--;
      if ($urandom_range(0, 3) == 0) sw = 3'($urandom_range(0, 7));
      clear = ($urandom_range(0, 19) == 0);
      step(1);
    end
    clear = 1'b0;
    confirm_btn = 1'b0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
